// File: rtl/video_dma_read_ctl_pkg.sv
// rtl/video_dma_read_ctl_pkg.sv - shared encodings for the video DMA read controller
// Contents: FSM state type, AXI INCR burst code, AXI OKAY response code.
package video_dma_read_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/video_dma_ar_gen.sv
// rtl/video_dma_ar_gen.sv - splits a frame into per-line AXI read bursts
// Ports: load (start of frame, takes base_addr), stride/width/height (latched frame
// geometry), issue_en/can_issue (FSM and outstanding gating), AR channel outputs
// araddr/arlen/arburst/arvalid with arready, last_hs (handshake of the final burst).
module video_dma_ar_gen
    import video_dma_read_ctl_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_SIZE  = 2,
    parameter int AXI4_LEN_WIDTH  = 8,
    parameter int MAX_BURST       = 16,
    parameter int H_WIDTH         = 14,
    parameter int V_WIDTH         = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [AXI4_ADDR_WIDTH-1:0] base_addr,
    input  logic [AXI4_ADDR_WIDTH-1:0] stride,
    input  logic [H_WIDTH-1:0]         width,
    input  logic [V_WIDTH-1:0]         height,
    input  logic                       issue_en,
    input  logic                       can_issue,
    input  logic                       arready,
    output logic [AXI4_ADDR_WIDTH-1:0] araddr,
    output logic [AXI4_LEN_WIDTH-1:0]  arlen,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    output logic                       last_hs
);

    localparam logic [H_WIDTH:0] BURST_MAX = (H_WIDTH+1)'(MAX_BURST);

    logic [AXI4_ADDR_WIDTH-1:0] line_base;
    logic [H_WIDTH-1:0]         beats_issued;
    logic [V_WIDTH-1:0]         lines_issued;
    logic [H_WIDTH-1:0]         cur_beats;
    logic                       cur_line_end;
    logic                       cur_last;
    logic [H_WIDTH:0]           remaining;
    logic [H_WIDTH:0]           burst_beats;
    logic                       line_done;

    // One extra bit keeps the remaining-beats arithmetic free of wrap.
    assign remaining   = {1'b0, width} - {1'b0, beats_issued};
    assign line_done   = remaining <= BURST_MAX;
    assign burst_beats = line_done ? remaining : BURST_MAX;
    assign last_hs     = arvalid && arready && cur_last;
    assign arburst     = AXI_BURST_INCR;

    // AR fields are only rewritten while arvalid is low, so they stay stable
    // for as long as the slave stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_base    <= '0;
            beats_issued <= '0;
            lines_issued <= '0;
            cur_beats    <= '0;
            cur_line_end <= 1'b0;
            cur_last     <= 1'b0;
            araddr       <= '0;
            arlen        <= '0;
            arvalid      <= 1'b0;
        end else if (load) begin
            line_base    <= base_addr;
            beats_issued <= '0;
            lines_issued <= '0;
            arvalid      <= 1'b0;
        end else if (arvalid) begin
            if (arready) begin
                arvalid <= 1'b0;
                if (cur_line_end) begin
                    beats_issued <= '0;
                    line_base    <= line_base + stride;
                    lines_issued <= lines_issued + V_WIDTH'(1);
                end else begin
                    beats_issued <= beats_issued + cur_beats;
                end
            end
        end else if (issue_en && can_issue) begin
            arvalid      <= 1'b1;
            araddr       <= line_base + (AXI4_ADDR_WIDTH'(beats_issued) << AXI4_DATA_SIZE);
            arlen        <= AXI4_LEN_WIDTH'(burst_beats - (H_WIDTH+1)'(1));
            cur_beats    <= burst_beats[H_WIDTH-1:0];
            cur_line_end <= line_done;
            cur_last     <= line_done && (lines_issued == height - V_WIDTH'(1));
        end
    end

endmodule

// File: rtl/video_dma_read_ctl.sv
// rtl/video_dma_read_ctl.sv - frame-based AXI4 read DMA producing a pixel stream
// Ports: clk/reset; ctl_enable/ctl_busy/ctl_error control; param_* frame geometry;
// m_axi4_ar*/m_axi4_r* AXI4 read master; m_data/m_frame_start/m_line_end/m_valid/m_ready stream.
module video_dma_read_ctl
    import video_dma_read_ctl_pkg::*;
#(
    parameter int AXI4_ID_WIDTH   = 6,
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_SIZE  = 2,
    parameter int AXI4_LEN_WIDTH  = 8,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int H_WIDTH         = 14,
    parameter int V_WIDTH         = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ctl_enable,
    output logic                          ctl_busy,
    output logic                          ctl_error,
    input  logic [AXI4_ADDR_WIDTH-1:0]    param_addr,
    input  logic [AXI4_ADDR_WIDTH-1:0]    param_stride,
    input  logic [H_WIDTH-1:0]            param_width,
    input  logic [V_WIDTH-1:0]            param_height,
    output logic [AXI4_ID_WIDTH-1:0]      m_axi4_arid,
    output logic [AXI4_ADDR_WIDTH-1:0]    m_axi4_araddr,
    output logic [AXI4_LEN_WIDTH-1:0]     m_axi4_arlen,
    output logic [2:0]                    m_axi4_arsize,
    output logic [1:0]                    m_axi4_arburst,
    output logic                          m_axi4_arvalid,
    input  logic                          m_axi4_arready,
    input  logic [AXI4_ID_WIDTH-1:0]      m_axi4_rid,
    input  logic [(8<<AXI4_DATA_SIZE)-1:0] m_axi4_rdata,
    input  logic [1:0]                    m_axi4_rresp,
    input  logic                          m_axi4_rlast,
    input  logic                          m_axi4_rvalid,
    output logic                          m_axi4_rready,
    output logic [(8<<AXI4_DATA_SIZE)-1:0] m_data,
    output logic                          m_frame_start,
    output logic                          m_line_end,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    state_t                     state;
    logic [AXI4_ADDR_WIDTH-1:0] stride_q;
    logic [H_WIDTH-1:0]         width_q;
    logic [V_WIDTH-1:0]         height_q;
    logic [H_WIDTH-1:0]         x;
    logic [V_WIDTH-1:0]         y;
    logic [OUT_WIDTH-1:0]       outstanding;
    logic                       load;
    logic                       frame_empty;
    logic                       issue_en;
    logic                       can_issue;
    logic                       ar_hs;
    logic                       ar_last_hs;
    logic                       r_hs;
    logic                       r_last_hs;
    logic                       drain_done;
    logic                       x_last;
    logic                       y_last;
    logic                       unused_rid;

    assign unused_rid = ^m_axi4_rid;

    assign m_data        = m_axi4_rdata;
    assign m_valid       = m_axi4_rvalid;
    assign m_axi4_rready = m_ready;
    assign m_axi4_arid   = '0;
    assign m_axi4_arsize = 3'(AXI4_DATA_SIZE);

    assign r_hs       = m_axi4_rvalid && m_ready;
    assign r_last_hs  = r_hs && m_axi4_rlast;
    assign ar_hs      = m_axi4_arvalid && m_axi4_arready;

    assign x_last        = x == width_q - H_WIDTH'(1);
    assign y_last        = y == height_q - V_WIDTH'(1);
    assign m_frame_start = (x == '0) && (y == '0);
    assign m_line_end    = x_last;

    assign frame_empty = (width_q == '0) || (height_q == '0);
    assign issue_en    = (state == ST_ISSUE) && !frame_empty;
    assign can_issue   = outstanding < OUT_WIDTH'(MAX_OUTSTANDING);
    // With no bursts outstanding every RLAST has been passed on; x/y back at the
    // origin confirms the stream side consumed the whole frame.
    assign drain_done  = (state == ST_DRAIN) && (outstanding == '0) && (x == '0) && (y == '0);
    assign load        = ctl_enable && ((state == ST_IDLE) || drain_done);

    video_dma_ar_gen #(
        .AXI4_ADDR_WIDTH (AXI4_ADDR_WIDTH),
        .AXI4_DATA_SIZE  (AXI4_DATA_SIZE),
        .AXI4_LEN_WIDTH  (AXI4_LEN_WIDTH),
        .MAX_BURST       (MAX_BURST),
        .H_WIDTH         (H_WIDTH),
        .V_WIDTH         (V_WIDTH)
    ) u_ar_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .base_addr (param_addr),
        .stride    (stride_q),
        .width     (width_q),
        .height    (height_q),
        .issue_en  (issue_en),
        .can_issue (can_issue),
        .arready   (m_axi4_arready),
        .araddr    (m_axi4_araddr),
        .arlen     (m_axi4_arlen),
        .arburst   (m_axi4_arburst),
        .arvalid   (m_axi4_arvalid),
        .last_hs   (ar_last_hs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctl_busy  <= 1'b0;
            ctl_error <= 1'b0;
            stride_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
        end else begin
            if (r_hs && (m_axi4_rresp != AXI_RESP_OKAY)) begin
                ctl_error <= 1'b1;
            end
            if (load) begin
                stride_q  <= param_stride;
                width_q   <= param_width;
                height_q  <= param_height;
                ctl_error <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state    <= ST_ISSUE;
                        ctl_busy <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (frame_empty || ar_last_hs) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        if (load) begin
                            state <= ST_ISSUE;
                        end else begin
                            state    <= ST_IDLE;
                            ctl_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ctl_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   outstanding <= outstanding + OUT_WIDTH'(1);
                2'b01:   outstanding <= outstanding - OUT_WIDTH'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (r_hs) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + V_WIDTH'(1);
            end else begin
                x <= x + H_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/video_dma_read_ctl.md
VIDEO_DMA_READ_CTL -- requirements
Module: video_dma_read_ctl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AXI4_ID_WIDTH, 6, ARID/RID width.
- AXI4_ADDR_WIDTH, 32, address width.
- AXI4_DATA_SIZE, 2, log2 bytes per beat (32-bit data).
- AXI4_LEN_WIDTH, 8, ARLEN width.
- MAX_BURST, 16, beats per burst.
- MAX_OUTSTANDING, 4, maximum in-flight read bursts.
- H_WIDTH, 14, line width in beats.
- V_WIDTH, 14, frame height in lines.
REQ-002 Ports (name, direction, width, meaning), one per line; all logic uses the single clock clk, and reset is synchronous and active-high:
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- ctl_enable, in, 1, run frames continuously while high.
- ctl_busy, out, 1, a frame is in progress.
- ctl_error, out, 1, sticky RRESP!=OKAY seen in the current frame.
- param_addr, in, AXI4_ADDR_WIDTH, frame base address.
- param_stride, in, AXI4_ADDR_WIDTH, line pitch in bytes.
- param_width, in, H_WIDTH, beats per line.
- param_height, in, V_WIDTH, lines per frame.
- m_axi4_arid/araddr/arlen/arsize/arburst/arvalid, out, AR channel fields.
- m_axi4_arready, in, 1, AR accept.
- m_axi4_rid/rdata/rresp/rlast/rvalid, in, R channel.
- m_axi4_rready, out, 1, R accept.
- m_data, out, 8<<AXI4_DATA_SIZE, pixel data.
- m_frame_start, out, 1, first beat of frame.
- m_line_end, out, 1, last beat of line.
- m_valid, out, 1, stream valid.
- m_ready, in, 1, stream ready.

Function
REQ-003 The FSM shall have states IDLE, ISSUE and DRAIN.
REQ-004 In IDLE with ctl_enable=1, the block shall latch all param_* into internal registers, clear ctl_error, assert ctl_busy and enter ISSUE on the next cycle.
REQ-005 If the latched width or height is 0, the block shall go straight from ISSUE to DRAIN without issuing any AR.
REQ-006 ISSUE shall split each line into bursts: ARLEN = min(remaining beats in line, MAX_BURST) - 1, ARADDR = line base + beats issued × 2^AXI4_DATA_SIZE.
REQ-007 Line base shall start at param_addr and advance by param_stride per line; the address shall wrap modulo 2^AXI4_ADDR_WIDTH.
REQ-008 AR fields shall be fixed as ARID=0, ARBURST=INCR (2'b01), ARSIZE=AXI4_DATA_SIZE.
REQ-009 ARVALID, once asserted, shall hold it and all AR fields stable until ARREADY.
REQ-010 ARVALID shall be asserted only while outstanding < MAX_OUTSTANDING.
REQ-011 The outstanding counter shall increment on AR handshake and decrement on an R handshake with RLAST; simultaneous events shall leave it unchanged.
REQ-012 After the AR handshake for the last burst of the last line, the FSM shall enter DRAIN.
REQ-013 DRAIN shall exit when outstanding==0 and all frame beats have been delivered.
REQ-014 On DRAIN exit with ctl_enable=1, the block shall re-latch parameters and enter ISSUE (back-to-back frames, ctl_busy stays high).
REQ-015 On DRAIN exit with ctl_enable=0, the block shall enter IDLE and deassert ctl_busy.
REQ-016 Deasserting ctl_enable mid-frame shall not abort the frame; the frame completes.
REQ-017 The R path shall be a zero-latency passthrough: m_data=RDATA, m_valid=RVALID, RREADY=m_ready.
REQ-018 Beat counters (x, y) shall advance on each stream handshake, independent of AR state.
REQ-019 m_frame_start shall be 1 when x==0 and y==0.
REQ-020 m_line_end shall be 1 when x==width-1.
REQ-021 x shall wrap to 0 at line end; y shall wrap to 0 at frame end.
REQ-022 ctl_error shall be set on any R handshake with RRESP!=2'b00 and held until the next frame latch.
REQ-023 The integrator shall keep param_addr and param_stride aligned to MAX_BURST×2^AXI4_DATA_SIZE bytes so no burst crosses a 4 KB boundary; the block shall not check this.

Reset
REQ-024 Synchronous reset shall force IDLE and clear outstanding, x, y and all counters.
REQ-025 Synchronous reset shall force ARVALID=0, ctl_busy=0 and ctl_error=0.
REQ-026 Reset mid-frame shall not drain in-flight bursts; interconnect quiescence is the system's responsibility.

Structure
REQ-027 A shared package shall hold the FSM state encoding, the INCR burst constant and the OKAY response constant.
REQ-028 The AR burst-splitting address generator shall be one sub-module, video_dma_ar_gen; stream marker generation stays in the top.

Verification
REQ-029 The bench shall cover these directed scenarios:
- addr=0x1000_0000, stride=0x100, width=40, height=2, MAX_BURST=16 -> AR sequence (0x1000_0000,len15), (0x1000_0040,len15), (0x1000_0080,len7), (0x1000_0100,len15), (0x1000_0140,len15), (0x1000_0180,len7); m_frame_start on beat 1, m_line_end on beats 40 and 80.
- ARREADY=1, RVALID=0, width=256 -> exactly 4 AR handshakes, then ARVALID=0 until the first RLAST.
- ARREADY held 0 for 10 cycles -> ARADDR/ARLEN unchanged throughout.
- height=0 with enable -> no AR issued, ctl_busy high for the frame, then back to IDLE.
- RRESP=2'b10 on one beat -> ctl_error=1 until the next frame start.
- Reset asserted mid-burst -> next cycle ARVALID=0, ctl_busy=0; a following enable starts from param_addr with m_frame_start on the first beat.
